// File: rtl/func_unit_r.sv
// R-type functional unit: latches one issued op, executes it (LAT_ALU or LAT_MUL cycles), then writes back over the CDB.
// Start-to-Cdb_req is LAT cycles; the result is held in WB until Cdb_grant, and Start is ignored while Fu_busy.
module func_unit_r #(
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 3,
  parameter int LAT_ALU = 1,
  parameter int LAT_MUL = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [2:0]        Ufop,
  input  logic [DATA_W-1:0] Vj,
  input  logic [DATA_W-1:0] Vk,
  input  logic [TAG_W-1:0]  Tag_in,
  input  logic [TAG_W-1:0]  R_target,
  input  logic              Flush,
  input  logic              Cdb_grant,
  output logic              Fu_busy,
  output logic              Cdb_req,
  output logic [DATA_W-1:0] Result,
  output logic [TAG_W-1:0]  Tag_out,
  output logic [TAG_W-1:0]  R_dest,
  output logic              Done
);

  localparam int LAT_MAX = (LAT_ALU > LAT_MUL) ? LAT_ALU : LAT_MUL;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [CNT_W-1:0] LD_ALU = CNT_W'(LAT_ALU - 1);
  localparam logic [CNT_W-1:0] LD_MUL = CNT_W'(LAT_MUL - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] vj_q;
  logic [DATA_W-1:0] vk_q;
  logic [TAG_W-1:0]  tag_q;
  logic [TAG_W-1:0]  rt_q;
  logic [DATA_W-1:0] alu_res;

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD: alu_res = vj_q + vk_q;
      OP_SUB: alu_res = vj_q - vk_q;
      OP_AND: alu_res = vj_q & vk_q;
      OP_OR:  alu_res = vj_q | vk_q;
      OP_SLT: alu_res[0] = ($signed(vj_q) < $signed(vk_q));
      OP_SLL: alu_res = vj_q << vk_q[3:0];
      OP_SRL: alu_res = vj_q >> vk_q[3:0];
      OP_MUL: alu_res = vj_q * vk_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_q    <= '0;
      vj_q    <= '0;
      vk_q    <= '0;
      tag_q   <= '0;
      rt_q    <= '0;
      Fu_busy <= 1'b0;
      Cdb_req <= 1'b0;
      Result  <= '0;
      Tag_out <= '0;
      R_dest  <= '0;
      Done    <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new issue just like IDLE so back-to-back ops lose no cycle.
        S_IDLE, S_DONE: begin
          Done    <= 1'b0;
          Cdb_req <= 1'b0;
          if (Start) begin
            op_q    <= Ufop;
            vj_q    <= Vj;
            vk_q    <= Vk;
            tag_q   <= Tag_in;
            rt_q    <= R_target;
            cnt     <= (Ufop == OP_MUL) ? LD_MUL : LD_ALU;
            Fu_busy <= 1'b1;
            state   <= S_EXEC;
          end else begin
            Fu_busy <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_EXEC: begin
          if (Flush) begin
            Fu_busy <= 1'b0;
            state   <= S_IDLE;
          end else if (cnt == '0) begin
            Result  <= alu_res;
            Tag_out <= tag_q;
            R_dest  <= rt_q;
            Cdb_req <= 1'b1;
            state   <= S_WB;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WB: begin
          if (Flush) begin
            Fu_busy <= 1'b0;
            Cdb_req <= 1'b0;
            state   <= S_IDLE;
          end else if (Cdb_grant) begin
            Fu_busy <= 1'b0;
            Cdb_req <= 1'b0;
            Done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        default: begin
          Fu_busy <= 1'b0;
          Cdb_req <= 1'b0;
          Done    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_func_unit_r.sv
// Directed bench for func_unit_r: stimulus pushes expected write-backs, a monitor pops them on every Done.
module tb_func_unit_r;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Ufop = '0;
  logic [15:0] Vj = '0;
  logic [15:0] Vk = '0;
  logic [2:0]  Tag_in = '0;
  logic [2:0]  R_target = '0;
  logic        Flush = 1'b0;
  logic        Cdb_grant = 1'b0;
  logic        Fu_busy;
  logic        Cdb_req;
  logic [15:0] Result;
  logic [2:0]  Tag_out;
  logic [2:0]  R_dest;
  logic        Done;

  func_unit_r #(.DATA_W(16), .TAG_W(3), .LAT_ALU(1), .LAT_MUL(3)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Ufop(Ufop), .Vj(Vj), .Vk(Vk),
    .Tag_in(Tag_in), .R_target(R_target), .Flush(Flush), .Cdb_grant(Cdb_grant),
    .Fu_busy(Fu_busy), .Cdb_req(Cdb_req), .Result(Result), .Tag_out(Tag_out),
    .R_dest(R_dest), .Done(Done)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  tag;
    logic [2:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic push(input logic [15:0] r, input logic [2:0] t, input logic [2:0] d);
    exp_t e;
    e.res = r; e.tag = t; e.rd = d;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] tg, input logic [2:0] rt);
    Ufop = op; Vj = a; Vk = b; Tag_in = tg; R_target = rt; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    @(negedge Clock);
    while (!Cdb_req && n < 20) begin
      @(negedge Clock);
      n++;
    end
    chk(nm, 16'(Cdb_req), 16'h1);
  endtask

  task automatic do_op(input string nm, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] tg, input logic [2:0] rt,
                       input logic [15:0] want);
    int n = 0;
    push(want, tg, rt);
    issue(op, a, b, tg, rt);
    @(negedge Clock);
    while (!Done && n < 20) begin
      @(negedge Clock);
      n++;
    end
    chk(nm, 16'(Done), 16'h1);
  endtask

  // Scoreboard monitor: every Done must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (Reset && Done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got Done=1 Result=%h Tag=%h want no Done", Result, Tag_out);
        end else begin
          e = exp_q.pop_front();
          chk("wb_result", Result, e.res);
          chk("wb_tag", 16'(Tag_out), 16'(e.tag));
          chk("wb_rdest", 16'(R_dest), 16'(e.rd));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;

    // Reset state
    @(negedge Clock);
    chk("rst_busy", 16'(Fu_busy), 16'h0);
    chk("rst_req", 16'(Cdb_req), 16'h0);
    chk("rst_done", 16'(Done), 16'h0);
    chk("rst_result", Result, 16'h0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;

    // ADD wrap-around with grant held high
    Cdb_grant = 1'b1;
    push(16'h0000, 3'd2, 3'd4);
    issue(3'b000, 16'hFFFF, 16'h0001, 3'd2, 3'd4);
    @(negedge Clock);
    chk("add_busy_exec", 16'(Fu_busy), 16'h1);
    chk("add_req_exec", 16'(Cdb_req), 16'h0);
    @(negedge Clock);
    chk("add_req_wb", 16'(Cdb_req), 16'h1);
    chk("add_done_wb", 16'(Done), 16'h0);
    @(negedge Clock);
    chk("add_done", 16'(Done), 16'h1);
    chk("add_req_done", 16'(Cdb_req), 16'h0);
    @(negedge Clock);
    chk("add_done_width", 16'(Done), 16'h0);

    // MUL with grant withheld for 4 WB cycles
    Cdb_grant = 1'b0;
    push(16'h5F90, 3'd6, 3'd1);
    issue(3'b111, 16'd300, 16'd300, 3'd6, 3'd1);
    @(negedge Clock);
    @(negedge Clock);
    @(negedge Clock);
    chk("mul_req_early", 16'(Cdb_req), 16'h0);
    @(negedge Clock);
    chk("mul_req", 16'(Cdb_req), 16'h1);
    chk("mul_result", Result, 16'h5F90);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("mul_hold_result", Result, 16'h5F90);
      chk("mul_hold_req", 16'(Cdb_req), 16'h1);
      chk("mul_hold_nodone", 16'(Done), 16'h0);
    end
    Cdb_grant = 1'b1;
    @(negedge Clock);
    chk("mul_done", 16'(Done), 16'h1);
    Cdb_grant = 1'b0;
    @(negedge Clock);
    chk("mul_done_width", 16'(Done), 16'h0);
    chk("mul_idle_busy", 16'(Fu_busy), 16'h0);

    // SLT / SRL / SUB, back-to-back with grant high
    Cdb_grant = 1'b1;
    do_op("slt_done", 3'b100, 16'h8000, 16'h0001, 3'd1, 3'd3, 16'h0001);
    do_op("srl_done", 3'b110, 16'h8000, 16'h0013, 3'd5, 3'd6, 16'h1000);
    do_op("sub_done", 3'b001, 16'h0003, 16'h0005, 3'd7, 3'd2, 16'hFFFE);
    @(negedge Clock);

    // Start while busy is ignored; Start in DONE is accepted
    Cdb_grant = 1'b0;
    push(16'd35, 3'd3, 3'd2);
    issue(3'b111, 16'd5, 16'd7, 3'd3, 3'd2);
    issue(3'b000, 16'd100, 16'd200, 3'd7, 3'd7);
    wait_req("busy_req");
    chk("busy_ignore_result", Result, 16'd35);
    chk("busy_ignore_tag", 16'(Tag_out), 16'h3);
    Cdb_grant = 1'b1;
    @(posedge Clock); #1;
    push(16'd30, 3'd1, 3'd6);
    issue(3'b000, 16'd10, 16'd20, 3'd1, 3'd6);
    @(negedge Clock);
    chk("b2b_busy", 16'(Fu_busy), 16'h1);
    chk("b2b_req_exec", 16'(Cdb_req), 16'h0);
    @(negedge Clock);
    chk("b2b_req", 16'(Cdb_req), 16'h1);
    @(negedge Clock);
    chk("b2b_done", 16'(Done), 16'h1);
    Cdb_grant = 1'b0;
    @(negedge Clock);

    // Flush beats grant in WB
    issue(3'b010, 16'hFFFF, 16'h0F0F, 3'd4, 3'd5);
    wait_req("flush_req");
    snap = done_cnt;
    Flush = 1'b1;
    Cdb_grant = 1'b1;
    @(posedge Clock); #1;
    Flush = 1'b0;
    Cdb_grant = 1'b0;
    @(negedge Clock);
    chk("flush_busy", 16'(Fu_busy), 16'h0);
    chk("flush_req_off", 16'(Cdb_req), 16'h0);
    chk("flush_nodone", 16'(Done), 16'h0);
    repeat (4) @(negedge Clock);
    chk("flush_done_count", 16'(done_cnt), 16'(snap));

    // Reset mid-EXEC of a MUL
    @(posedge Clock); #1;
    snap = done_cnt;
    issue(3'b111, 16'd9, 16'd9, 3'd2, 3'd2);
    #2;
    Reset = 1'b0;
    #1;
    chk("arst_busy", 16'(Fu_busy), 16'h0);
    chk("arst_req", 16'(Cdb_req), 16'h0);
    chk("arst_done", 16'(Done), 16'h0);
    chk("arst_result", Result, 16'h0);
    chk("arst_tag", 16'(Tag_out), 16'h0);
    chk("arst_rdest", 16'(R_dest), 16'h0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    repeat (8) @(negedge Clock);
    chk("arst_no_done", 16'(done_cnt), 16'(snap));
    chk("arst_idle", 16'(Fu_busy), 16'h0);
    chk("queue_empty", 16'(exp_q.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
